bin_to_bcd_seq: RTL

//   Sequential, parametrised binary-to-BCD converter (shift-add-3 / double-dabble).

---
 rtl/bin_to_bcd_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential WIDTH-bit binary to DIGITS-digit BCD converter
//                (shift-add-3) with start/busy/done and leading-zero blanking.
//  Revision    : 1.0  initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank
);

    localparam int c_CW = $clog2(WIDTH + 1);
    localparam int c_AW = 4 * DIGITS;

    function automatic logic [63:0] f_pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] c_DEC_RANGE = f_pow10(DIGITS);
    localparam logic [63:0] c_BIN_RANGE = 64'd1 << WIDTH;
    localparam logic [DIGITS-1:0] c_BLANK_RST = ~(DIGITS'(1));

    // Every binary value must be representable in DIGITS decimal digits.
    generate
        if (WIDTH < 1 || WIDTH > 60 || DIGITS < 1 || DIGITS > 18 ||
            c_DEC_RANGE < c_BIN_RANGE) begin : g_bad_params
            $error("bin_to_bcd_seq: 10**DIGITS must exceed 2**WIDTH-1");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_bin;
    logic [c_AW-1:0]    r_acc;
    logic [c_CW-1:0]    r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [c_AW-1:0]    r_bcd;
    logic [DIGITS-1:0]  r_blank;

    logic [c_AW-1:0]    w_adj;
    logic [c_AW-1:0]    w_acc_next;
    logic [WIDTH-1:0]   w_bin_next;
    logic [DIGITS:0]    w_zero_from;
    logic [DIGITS-1:0]  w_blank;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_add3
            assign w_adj[4*k +: 4] = (r_acc[4*k +: 4] >= 4'd5) ?
                                     (r_acc[4*k +: 4] + 4'd3) : r_acc[4*k +: 4];
        end
    endgenerate

    assign w_acc_next = {w_adj[c_AW-2:0], r_bin[WIDTH-1]};
    assign w_bin_next = r_bin << 1;

    // w_zero_from[k]: digits k..DIGITS-1 of the final value are all zero.
    assign w_zero_from[DIGITS] = 1'b1;
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_blank
            assign w_zero_from[k] = (w_acc_next[4*k +: 4] == 4'd0) & w_zero_from[k+1];
        end
    endgenerate

    assign w_blank = w_zero_from[DIGITS-1:0] & c_BLANK_RST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
            r_blank <= c_BLANK_RST;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_bin   <= bin_in;
                        r_acc   <= '0;
                        r_cnt   <= c_CW'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_bin <= w_bin_next;
                    r_cnt <= r_cnt - c_CW'(1);
                    if (r_cnt == c_CW'(1)) begin
                        r_bcd   <= w_acc_next;
                        r_blank <= w_blank;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_bcd;
    assign blank   = r_blank;

endmodule
`default_nettype wire
